// File: rtl/cordic_vector_if.sv
// Handshake and data bundle for the vectoring CORDIC: sample in, polar result out.
// Signal names match the block's port list so waveforms read the same from either side.
interface cordic_vector_if #(
    parameter int DW = 8,
    parameter int AW = 11
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic signed [DW-1:0] x_i;
    logic signed [DW-1:0] y_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic signed [AW-1:0] angle_o;
    logic        [9:0]    mag_o;

    modport slave (
        input  in_valid_i, x_i, y_i, out_ready_i,
        output in_ready_o, out_valid_o, angle_o, mag_o
    );

    modport master (
        output in_valid_i, x_i, y_i, out_ready_i,
        input  in_ready_o, out_valid_o, angle_o, mag_o
    );
endinterface

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: one micro-rotation per clock, returns atan2(y, x)
// in 256 LSB/rad units and the gain-scaled magnitude.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready_o = 1
// BUSY  | eight micro-rotations, step_q = 0..7
// DONE  | result presented, out_valid_o = 1 until out_ready_i
module cordic_vector #(
    parameter int DW = 8,
    parameter int IW = 11,
    parameter int AW = 11
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    cordic_vector_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [AW-1:0] ANG_PI = AW'(804);

    state_t               state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic signed [IW-1:0] x_q, x_d;
    logic signed [IW-1:0] y_q, y_d;
    logic signed [AW-1:0] z_q, z_d;
    logic                 zero_q, zero_d;
    logic signed [AW-1:0] angle_q, angle_d;
    logic [9:0]           mag_q, mag_d;

    logic signed [IW-1:0] x_in, y_in;
    logic signed [IW-1:0] x_sh, y_sh;
    logic signed [AW-1:0] atan_step;

    function automatic logic signed [AW-1:0] atan_lut(input logic [2:0] i);
        logic signed [AW-1:0] a;
        case (i)
            3'd0:    a = AW'(201);
            3'd1:    a = AW'(119);
            3'd2:    a = AW'(63);
            3'd3:    a = AW'(32);
            3'd4:    a = AW'(16);
            3'd5:    a = AW'(8);
            3'd6:    a = AW'(4);
            default: a = AW'(2);
        endcase
        return a;
    endfunction

    // Widening before the pre-rotation keeps -(-128) representable.
    assign x_in = {{(IW-DW){bus.x_i[DW-1]}}, bus.x_i};
    assign y_in = {{(IW-DW){bus.y_i[DW-1]}}, bus.y_i};

    assign x_sh      = x_q >>> step_q;
    assign y_sh      = y_q >>> step_q;
    assign atan_step = atan_lut(step_q);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    state_d = S_BUSY;
                    step_d  = 3'd0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    if (x_in[IW-1]) begin
                        x_d = -x_in;
                        y_d = -y_in;
                        z_d = y_in[IW-1] ? -ANG_PI : ANG_PI;
                    end else begin
                        x_d = x_in;
                        y_d = y_in;
                        z_d = '0;
                    end
                end
            end

            S_BUSY: begin
                if (!y_q[IW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_step;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_step;
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = S_DONE;
                    angle_d = zero_q ? '0 : z_d;
                    mag_d   = zero_q ? '0 : x_d[9:0];
                end
            end

            S_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.angle_o     = angle_q;
    assign bus.mag_o       = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Directed and randomized checks of cordic_vector against an arithmetic
// atan2/magnitude reference model.
module tb_cordic_vector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_vector_if #(.DW(8), .AW(11)) bus();

    cordic_vector #(.DW(8), .IW(11), .AW(11)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int n_in   = 0;
    int n_out  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert (((obs - exp) <= tol && (exp - obs) <= tol) === 1'b1) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d +-%0d", tag, obs, exp, tol);
        end
    endtask

    // Plain-integer vectoring CORDIC: 180-degree pre-rotation, then eight
    // floor-shift micro-rotations driving y toward zero.
    function automatic void ref_model(input int xi, input int yi, output int ang, output int mag);
        int atab [8] = '{201, 119, 63, 32, 16, 8, 4, 2};
        int x, y, z, xn;
        if (xi == 0 && yi == 0) begin
            ang = 0;
            mag = 0;
            return;
        end
        if (xi < 0) begin
            x = -xi;
            y = -yi;
            z = (yi >= 0) ? 804 : -804;
        end else begin
            x = xi;
            y = yi;
            z = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atab[i];
            end else begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atab[i];
            end
            x = xn;
        end
        ang = z;
        mag = x & 1023;
    endfunction

    function automatic int obs_angle();
        return int'(bus.angle_o);
    endfunction

    function automatic int obs_mag();
        return int'(bus.mag_o);
    endfunction

    // Offer a sample, wait for acceptance, then run to DONE checking latency
    // and in_ready; optionally wiggle inputs and in_valid during BUSY.
    task automatic run_txn(input int xi, input int yi, input bit disturb,
                           output int ang, output int mag);
        int n;
        int lat;
        bit rdy_seen;
        logic [7:0] xv, yv;
        xv = 8'(xi);
        yv = 8'(yi);
        bus.x_i = xv;
        bus.y_i = yv;
        bus.in_valid_i = 1'b1;
        n = 0;
        while (!bus.in_ready_o && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("accept_timeout", 0, 1);
        tick();
        n_in++;
        bus.in_valid_i = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid_o && lat < 20) begin
            if (bus.in_ready_o) rdy_seen = 1'b1;
            if (disturb) begin
                bus.x_i = 8'($urandom);
                bus.y_i = 8'($urandom);
                bus.in_valid_i = 1'($urandom);
            end
            tick();
            lat++;
        end
        bus.in_valid_i = 1'b0;
        chk("latency", lat, 8);
        chk("in_ready_low_busy", int'(rdy_seen), 0);
        ang = obs_angle();
        mag = obs_mag();
    endtask

    // Hold off for hold cycles (checking stability), then complete the transfer.
    task automatic drain(input int hold);
        int a0, m0;
        a0 = obs_angle();
        m0 = obs_mag();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_valid", int'(bus.out_valid_o), 1);
            chk("bp_angle", obs_angle(), a0);
            chk("bp_mag", obs_mag(), m0);
            chk("bp_in_ready", int'(bus.in_ready_o), 0);
        end
        bus.out_ready_i = 1'b1;
        tick();
        n_out++;
        bus.out_ready_i = 1'b0;
        chk("post_xfer_in_ready", int'(bus.in_ready_o), 1);
        chk("post_xfer_valid", int'(bus.out_valid_o), 0);
    endtask

    task automatic directed(input string tag, input int xi, input int yi,
                            input int sp_ang, input int sp_mag, input bit use_mag);
        int a, m, ea, em;
        run_txn(xi, yi, 1'b0, a, m);
        ref_model(xi, yi, ea, em);
        chk({tag, "_angle_model"}, a, ea);
        chk({tag, "_mag_model"}, m, em);
        chk_tol({tag, "_angle_nominal"}, a, sp_ang, 4);
        if (use_mag) chk_tol({tag, "_mag_nominal"}, m, sp_mag, 4);
        drain(0);
    endtask

    initial begin
        int a, m, ea, em, xi, yi, n, gap;
        bit r, xfer, early;

        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.x_i = '0;
        bus.y_i = '0;

        // Reset state, observed while reset is held.
        #12;
        chk("rst_in_ready", int'(bus.in_ready_o), 1);
        chk("rst_out_valid", int'(bus.out_valid_o), 0);
        chk("rst_angle", obs_angle(), 0);
        chk("rst_mag", obs_mag(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        directed("pos_x", 100, 0, 1, 166, 1'b1);
        directed("pos_y", 0, 100, 405, 165, 1'b1);
        directed("neg_x", -100, 0, 804, 0, 1'b0);
        directed("neg_y", 0, -100, -402, 0, 1'b0);
        directed("min_min", -128, -128, -603, 298, 1'b1);
        directed("max_max", 127, 127, 201, 296, 1'b1);

        run_txn(0, 0, 1'b0, a, m);
        chk("zero_angle", a, 0);
        chk("zero_mag", m, 0);
        drain(0);

        // Input wiggles and in_valid pulses during BUSY must not leak in.
        run_txn(-57, 93, 1'b1, a, m);
        ref_model(-57, 93, ea, em);
        chk("disturb_angle", a, ea);
        chk("disturb_mag", m, em);
        drain(5);
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid_o) early = 1'b1;
        end
        chk("no_phantom_txn", int'(early), 0);

        // Reset at step 4 drops the sample and clears the held result.
        bus.x_i = 8'(50);
        bus.y_i = 8'(30);
        bus.in_valid_i = 1'b1;
        tick();
        n_in++;
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready_o), 1);
        chk("midrst_valid", int'(bus.out_valid_o), 0);
        chk("midrst_angle", obs_angle(), 0);
        chk("midrst_mag", obs_mag(), 0);
        n_in--;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        early = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid_o) early = 1'b1;
            tick();
        end
        chk("midrst_no_valid", int'(early), 0);
        directed("after_rst", 100, 0, 1, 166, 1'b1);

        // Random back-to-back samples with random output backpressure.
        for (int t = 0; t < 60; t++) begin
            xi = int'($signed(8'($urandom)));
            yi = int'($signed(8'($urandom)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            run_txn(xi, yi, 1'b0, a, m);
            ref_model(xi, yi, ea, em);
            chk("rand_angle", a, ea);
            chk("rand_mag", m, em);
            n = 0;
            xfer = 1'b0;
            while (!xfer && n < 50) begin
                chk("rand_hold_angle", obs_angle(), ea);
                r = 1'($urandom);
                bus.out_ready_i = r;
                tick();
                if (r) begin
                    xfer = 1'b1;
                    n_out++;
                end
                n++;
            end
            bus.out_ready_i = 1'b0;
            if (!xfer) chk("rand_xfer_timeout", 0, 1);
            chk("rand_ready_after", int'(bus.in_ready_o), 1);
        end

        chk("out_count", n_out, n_in);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
